shift_cmd_buffer: RTL and testbench

//  Command buffer and result register for the combinational shift_unit.

---
 rtl/shift_cmd_buffer.sv | 137 +++++++++++++
 tb/tb_shift_cmd_buffer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_cmd_buffer.sv
// shift_cmd_buffer: command FIFO in front of a combinational shift_unit plus a
// registered result stage behind it. The FIFO head drives the shift_unit inputs;
// the shift_unit output is captured into res_data on each pop.
// Optional feature macro: SHIFT_ERR_EN (drops reserved-mode commands, pulses err).
`timescale 1ns/1ps

module shift_cmd_buffer #(
    parameter int DATA_W  = 8,
    parameter int SHIFT_W = 3,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [SHIFT_W-1:0]         in_shift,
    input  logic [1:0]                 in_mode,
    output logic [DATA_W-1:0]          su_data_in,
    output logic [SHIFT_W-1:0]         su_shift,
    output logic [1:0]                 su_mode,
    input  logic [DATA_W-1:0]          su_data_out,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [DATA_W-1:0]          res_data,
    output logic [1:0]                 res_mode,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [SHIFT_W-1:0] shift;
        logic [1:0]         mode;
    } cmd_t;

    cmd_t               mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               res_valid_q;
    logic [DATA_W-1:0]  res_data_q;
    logic [1:0]         res_mode_q;

    logic full, empty, push, wr_en, pop;
    cmd_t head;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // in_ready is forced low during reset so no handshake can complete then.
    assign in_ready = !rst && !full;
    assign push     = in_valid && in_ready;

`ifdef SHIFT_ERR_EN
    // Reserved-mode commands complete the handshake but never enter the FIFO.
    assign wr_en = push && (in_mode != 2'b11);

    logic err_q;

    // err pulses for exactly one cycle after a reserved-mode command is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= push && (in_mode == 2'b11);
    end

    assign err = err_q;
`else
    assign wr_en = push;
    assign err   = 1'b0;
`endif

    // Pop when there is a head entry and the result register is free or draining.
    assign pop  = !empty && (!res_valid_q || res_ready);
    assign head = mem_q[rd_ptr_q];

    // Shift_unit inputs show the head entry, or zeros while the FIFO is empty.
    assign su_data_in = empty ? '0 : head.data;
    assign su_shift   = empty ? '0 : head.shift;
    assign su_mode    = empty ? '0 : head.mode;

    // Occupancy next-state: a simultaneous write and pop leaves it unchanged.
    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage write port.
    // NOTE: the array is deliberately left out of reset; entries are only read
    // after being written, and resetting storage costs reset fan-out for nothing.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= '{data: in_data, shift: in_shift, mode: in_mode};
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments for all state so every flop samples
        // pre-edge values regardless of statement order.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Result register: load on pop, clear valid when consumed with nothing new.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_mode_q  <= '0;
        end else if (pop) begin
            res_valid_q <= 1'b1;
            res_data_q  <= su_data_out;
            res_mode_q  <= head.mode;
        end else if (res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_mode  = res_mode_q;
    assign count     = count_q;

endmodule

// File: tb/tb_shift_cmd_buffer.sv
// Testbench for shift_cmd_buffer: a behavioural shift_unit closes the loop, a
// scoreboard queue holds expected results in command order, and a monitor pops
// and compares whenever a result transfer is about to complete.
`timescale 1ns/1ps

module tb_shift_cmd_buffer;

    localparam int DATA_W  = 8;
    localparam int SHIFT_W = 3;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [1:0]        mode;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic [SHIFT_W-1:0] in_shift;
    logic [1:0]         in_mode;
    logic [DATA_W-1:0]  su_data_in;
    logic [SHIFT_W-1:0] su_shift;
    logic [1:0]         su_mode;
    logic [DATA_W-1:0]  su_data_out;
    logic               res_valid;
    logic               res_ready;
    logic [DATA_W-1:0]  res_data;
    logic [1:0]         res_mode;
    logic [CNT_W-1:0]   count;
    logic               err;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    shift_cmd_buffer #(.DATA_W(DATA_W), .SHIFT_W(SHIFT_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shift(in_shift), .in_mode(in_mode),
        .su_data_in(su_data_in), .su_shift(su_shift), .su_mode(su_mode),
        .su_data_out(su_data_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_mode(res_mode),
        .count(count), .err(err)
    );

    always #5 clk = ~clk;

    // Reference shift semantics; mode 11 passes the operand through.
    function automatic logic [DATA_W-1:0] shift_ref(input logic [DATA_W-1:0] d,
                                                    input logic [SHIFT_W-1:0] s,
                                                    input logic [1:0] m);
        case (m)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return DATA_W'($signed(d) >>> s);
            default: return d;
        endcase
    endfunction

    // Behavioural combinational shift_unit.
    assign su_data_out = shift_ref(su_data_in, su_shift, su_mode);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result monitor: compares each result as its transfer is about to complete.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'(res_data), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res_data", 32'(res_data), 32'(e.data));
                check("res_mode", 32'(res_mode), 32'(e.mode));
            end
        end
    end

    // Drive one command and hold it until accepted; called just after a rising edge.
    task automatic push(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_shift = s;
        in_mode  = m;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) begin
            check("push_timeout", 32'd0, 32'd1);
        end else begin
`ifdef SHIFT_ERR_EN
            if (m != 2'b11) sb.push_back('{data: shift_ref(d, s, m), mode: m});
`else
            sb.push_back('{data: shift_ref(d, s, m), mode: m});
`endif
        end
    endtask

    // Wait (bounded) until every expected result has been consumed.
    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0 && !res_valid) break;
            @(posedge clk);
            #1;
        end
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shift  = '0;
        in_mode   = '0;
        res_ready = 1'b1;

        // Reset state.
        #12;
        check("rst_count", 32'(count), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_mode", 32'(res_mode), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_su_data_in", 32'(su_data_in), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // T1 latency.
        push(8'h3C, 3'd3, 2'b00);
        check("t1_count_after_push", 32'(count), 32'd1);
        check("t1_res_valid_early", 32'(res_valid), 32'd0);
        check("t1_su_data_in", 32'(su_data_in), 32'h3C);
        @(posedge clk);
        #1;
        check("t1_res_valid", 32'(res_valid), 32'd1);
        check("t1_res_data", 32'(res_data), 32'hE0);
        check("t1_res_mode", 32'(res_mode), 32'd0);
        check("t1_count_back", 32'(count), 32'd0);
        wait_drain("t1_drain");
        check("t1_su_empty", 32'(su_data_in), 32'd0);

        // T2 order, back-to-back.
        push(8'hB1, 3'd2, 2'b01);
        push(8'hD0, 3'd2, 2'b10);
        push(8'h8F, 3'd0, 2'b10);
        check("t2_second", 32'(res_data), 32'hF4);
        @(posedge clk);
        #1;
        check("t2_third_valid", 32'(res_valid), 32'd1);
        check("t2_third", 32'(res_data), 32'h8F);
        wait_drain("t2_drain");

        // T3 full FIFO with back-pressure.
        res_ready = 1'b0;
        push(8'h11, 3'd1, 2'b00);
        push(8'h80, 3'd7, 2'b10);
        push(8'hF0, 3'd4, 2'b01);
        push(8'h81, 3'd1, 2'b10);
        push(8'h7F, 3'd2, 2'b00);
        check("t3_count_full", 32'(count), 32'd4);
        check("t3_in_ready_full", 32'(in_ready), 32'd0);
        check("t3_res_held", 32'(res_data), 32'h22);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        in_shift = 3'd1;
        in_mode  = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("t3_count_stuck", 32'(count), 32'd4);
        check("t3_res_still_held", 32'(res_data), 32'h22);
        check("t3_res_mode_held", 32'(res_mode), 32'd0);
        in_valid  = 1'b0;
        res_ready = 1'b1;
        wait_drain("t3_drain");

        // T4 simultaneous push and pop, then wrap with 3*DEPTH commands.
        res_ready = 1'b0;
        push(8'h01, 3'd1, 2'b00);
        push(8'h02, 3'd1, 2'b00);
        push(8'h03, 3'd1, 2'b00);
        check("t4_count_two", 32'(count), 32'd2);
        res_ready = 1'b1;
        push(8'h04, 3'd1, 2'b00);
        check("t4_count_simul", 32'(count), 32'd2);
        for (int i = 0; i < 3 * DEPTH; i++) begin
            push(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 2)));
        end
        wait_drain("t4_drain");

        // T5 reset in the middle of operation.
        res_ready = 1'b0;
        push(8'h10, 3'd1, 2'b00);
        push(8'h20, 3'd1, 2'b00);
        push(8'h30, 3'd1, 2'b00);
        push(8'h40, 3'd1, 2'b00);
        check("t5_count_pre", 32'(count), 32'd3);
        check("t5_res_valid_pre", 32'(res_valid), 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t5_count", 32'(count), 32'd0);
        check("t5_res_valid", 32'(res_valid), 32'd0);
        check("t5_res_data", 32'(res_data), 32'd0);
        check("t5_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        push(8'hC3, 3'd1, 2'b01);
        wait_drain("t5_drain");

        // T6 reserved mode.
        push(8'h55, 3'd1, 2'b11);
`ifdef SHIFT_ERR_EN
        check("t6_err_pulse", 32'(err), 32'd1);
        check("t6_count", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        check("t6_err_clear", 32'(err), 32'd0);
        check("t6_no_result", 32'(res_valid), 32'd0);
`else
        check("t6_err_tied", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        check("t6_res_valid", 32'(res_valid), 32'd1);
        check("t6_res_mode", 32'(res_mode), 32'd3);
`endif
        repeat (3) @(posedge clk);
        #1;
        wait_drain("t6_drain");
        check("final_count", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
